// File: rtl/i2c_clkgen.sv
// I2C quarter-phase clock generator.
// Derives the SCL phase and the data-launch phase from the system clock with a
// runtime standard/fast divider, phase-edge strobes, a quarter index and
// bounded slave clock-stretch detection with a sticky timeout flag.
module i2c_clkgen #(
    parameter int DIV_STD     = 125,
    parameter int DIV_FAST    = 31,
    parameter int CBITS       = 9,
    parameter int STRETCH_MAX = 1023,
    parameter int TBITS       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       mode,
    input  logic       scl_not_ena,
    input  logic       scl_in,
    output logic       scl_clk,
    output logic       data_clk,
    output logic       data_rise,
    output logic       scl_rise,
    output logic [1:0] quarter,
    output logic       stretching,
    output logic       stretch_to
);

    localparam logic [CBITS-1:0] C_DIV_STD   = CBITS'(DIV_STD);
    localparam logic [CBITS-1:0] C_DIV_FAST  = CBITS'(DIV_FAST);
    localparam logic [TBITS-1:0] C_TMAX      = TBITS'(STRETCH_MAX);

    // Phase counter, active divider and stretch timer
    logic [CBITS-1:0] r_cnt;
    logic [CBITS-1:0] r_div;
    logic [TBITS-1:0] r_tcnt;

    // Registered outputs
    logic       r_scl_clk;
    logic       r_data_clk;
    logic       r_data_rise;
    logic       r_scl_rise;
    logic [1:0] r_quarter;
    logic       r_stretching;
    logic       r_stretch_to;

    // Combinational next-state terms
    logic [CBITS-1:0] w_mode_div;
    logic [CBITS-1:0] w_last;
    logic [CBITS-1:0] w_d2;
    logic [CBITS-1:0] w_d3;
    logic             w_wrap;
    logic             w_hold_req;
    logic             w_timeout;
    logic             w_hold;
    logic [CBITS-1:0] w_cnt_next;
    logic [1:0]       w_q;
    logic             w_scl_next;
    logic             w_data_next;

    // Divider selection, wrap/hold arbitration and quarter decode of the new count
    always_comb begin
        w_mode_div = mode ? C_DIV_FAST : C_DIV_STD;
        // 4D-1 computed modulo 2^CBITS, which is exact even when 4D == 2^CBITS
        w_last     = (r_div << 2) - CBITS'(1);
        w_d2       = r_div << 1;
        w_d3       = w_d2 + r_div;
        w_wrap     = (r_cnt >= w_last);

        // A slave may only stretch while SCL is meant to be high (quarter 2),
        // and only until the timeout has fired once.
        w_hold_req = (r_quarter == 2'd2) && !scl_in && !scl_not_ena && !r_stretch_to;
        w_timeout  = w_hold_req && (r_tcnt == C_TMAX);
        // Wrap wins over hold so a degenerate divider can never lock the counter
        w_hold     = w_hold_req && !w_timeout && !w_wrap;

        if (w_wrap) begin
            w_cnt_next = '0;
        end else if (w_hold) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + CBITS'(1);
        end

        // Outside a wrap the divider is unchanged, and on a wrap cnt is 0 so
        // the decode is q0 whichever divider is used.
        if (w_cnt_next < r_div) begin
            w_q = 2'd0;
        end else if (w_cnt_next < w_d2) begin
            w_q = 2'd1;
        end else if (w_cnt_next < w_d3) begin
            w_q = 2'd2;
        end else begin
            w_q = 2'd3;
        end

        w_scl_next  = w_q[1];
        w_data_next = w_q[1] ^ w_q[0];
    end

    // Counter, divider, stretch timer and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_div        <= C_DIV_STD;
            r_tcnt       <= '0;
            r_scl_clk    <= 1'b0;
            r_data_clk   <= 1'b0;
            r_data_rise  <= 1'b0;
            r_scl_rise   <= 1'b0;
            r_quarter    <= 2'd0;
            r_stretching <= 1'b0;
            r_stretch_to <= 1'b0;
        end else if (!ena) begin
            // Parked: divider tracks mode so the next run starts at the chosen rate
            r_cnt        <= '0;
            r_div        <= w_mode_div;
            r_tcnt       <= '0;
            r_scl_clk    <= 1'b0;
            r_data_clk   <= 1'b0;
            r_data_rise  <= 1'b0;
            r_scl_rise   <= 1'b0;
            r_quarter    <= 2'd0;
            r_stretching <= 1'b0;
            r_stretch_to <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            // Mode only takes effect at a period boundary
            if (w_wrap) begin
                r_div <= w_mode_div;
            end
            r_tcnt <= w_hold ? (r_tcnt + TBITS'(1)) : '0;
            if (w_timeout) begin
                r_stretch_to <= 1'b1;
            end
            r_scl_clk    <= w_scl_next;
            r_data_clk   <= w_data_next;
            r_data_rise  <= w_data_next && !r_data_clk;
            r_scl_rise   <= w_scl_next && !r_scl_clk;
            r_quarter    <= w_q;
            r_stretching <= w_hold;
        end
    end

    assign scl_clk    = r_scl_clk;
    assign data_clk   = r_data_clk;
    assign data_rise  = r_data_rise;
    assign scl_rise   = r_scl_rise;
    assign quarter    = r_quarter;
    assign stretching = r_stretching;
    assign stretch_to = r_stretch_to;

endmodule

// File: tb/tb_i2c_clkgen.sv
// Directed bench for i2c_clkgen: DIV_STD=5, DIV_FAST=2. Instance A has a long
// stretch limit for the hold tests, instance B a limit of 4 for the timeout test.
module tb_i2c_clkgen;

    logic       clk = 1'b0;
    logic       rst, ena, mode, scl_not_ena, scl_in;

    logic       a_scl_clk, a_data_clk, a_data_rise, a_scl_rise;
    logic [1:0] a_quarter;
    logic       a_stretching, a_stretch_to;

    logic       b_scl_clk, b_data_clk, b_data_rise, b_scl_rise;
    logic [1:0] b_quarter;
    logic       b_stretching, b_stretch_to;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i2c_clkgen #(
        .DIV_STD(5), .DIV_FAST(2), .CBITS(9), .STRETCH_MAX(50), .TBITS(10)
    ) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode),
        .scl_not_ena(scl_not_ena), .scl_in(scl_in),
        .scl_clk(a_scl_clk), .data_clk(a_data_clk), .data_rise(a_data_rise),
        .scl_rise(a_scl_rise), .quarter(a_quarter),
        .stretching(a_stretching), .stretch_to(a_stretch_to)
    );

    i2c_clkgen #(
        .DIV_STD(5), .DIV_FAST(2), .CBITS(9), .STRETCH_MAX(4), .TBITS(10)
    ) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode),
        .scl_not_ena(scl_not_ena), .scl_in(scl_in),
        .scl_clk(b_scl_clk), .data_clk(b_data_clk), .data_rise(b_data_rise),
        .scl_rise(b_scl_rise), .quarter(b_quarter),
        .stretching(b_stretching), .stretch_to(b_stretch_to)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] a_outs();
        return {a_scl_clk, a_data_clk, a_data_rise, a_scl_rise,
                a_quarter, a_stretching, a_stretch_to};
    endfunction

    // Advance n edges from count c0 with divider d; check every output of A
    // against the ideal waveform for the count reached.
    task automatic run(input string ph, input int d, input int c0, input int n);
        int c;
        for (int i = 1; i <= n; i++) begin
            tick();
            c = (c0 + i) % (4 * d);
            check({ph, " data_clk"},  a_data_clk,  (c >= d) && (c < 3 * d));
            check({ph, " scl_clk"},   a_scl_clk,   (c >= 2 * d));
            check({ph, " data_rise"}, a_data_rise, (c == d));
            check({ph, " scl_rise"},  a_scl_rise,  (c == 2 * d));
            check({ph, " quarter"},   a_quarter,   c / d);
            check({ph, " stretching"}, a_stretching, 0);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; mode = 1'b1; scl_not_ena = 1'b0; scl_in = 1'b1;

        // Reset overrides ena and mode
        tick(); tick();
        check("reset outs A", a_outs(), 0);
        check("reset stretch_to B", b_stretch_to, 0);
        $display("phase reset done");

        // Two standard periods
        rst = 1'b0; mode = 1'b0;
        run("std", 5, 0, 40);
        $display("phase standard periods done");

        // Mode change mid-period: current period completes, next is fast
        run("pre_toggle", 5, 0, 7);
        mode = 1'b1;
        run("post_toggle", 5, 7, 13);
        run("fast1", 2, 0, 4);
        mode = 1'b0;
        run("fast2", 2, 4, 4);
        $display("phase mode switch done");

        // Slave stretch for 6 cycles at cnt=11
        run("to11", 5, 0, 11);
        scl_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("hold stretching", a_stretching, 1);
            check("hold scl_clk",    a_scl_clk,    1);
            check("hold data_clk",   a_data_clk,   1);
            check("hold quarter",    a_quarter,    2);
            check("hold scl_rise",   a_scl_rise,   0);
        end
        scl_in = 1'b1;
        run("after_hold", 5, 11, 9);
        $display("phase stretch hold done");

        // Master not driving SCL: no stretch detection
        scl_not_ena = 1'b1; scl_in = 1'b0;
        run("no_drive", 5, 0, 20);
        scl_not_ena = 1'b0; scl_in = 1'b1;
        $display("phase scl_not_ena done");

        // Stretch timeout on instance B (STRETCH_MAX=4), scl_in stuck low
        ena = 1'b0; scl_in = 1'b0;
        tick();
        check("ena0 outs A", a_outs(), 0);
        check("ena0 stretch_to B", b_stretch_to, 0);
        ena = 1'b1;
        repeat (10) tick();
        check("B reach q2", b_quarter, 2);
        check("B no hold yet", b_stretching, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("B hold stretching", b_stretching, 1);
            check("B hold quarter",    b_quarter,    2);
            check("B hold to",         b_stretch_to, 0);
        end
        tick();
        check("B timeout stretching", b_stretching, 0);
        check("B timeout flag",       b_stretch_to, 1);
        check("B timeout quarter",    b_quarter,    2);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("B post_to stretching", b_stretching, 0);
            check("B post_to flag",       b_stretch_to, 1);
        end
        ena = 1'b0;
        tick();
        check("B ena0 clears flag",  b_stretch_to, 0);
        check("B ena0 stretching",   b_stretching, 0);
        $display("phase stretch timeout done");

        // Reset mid-period with mode=1: restart at standard rate
        rst = 1'b1; ena = 1'b1; scl_in = 1'b1; mode = 1'b0;
        tick();
        rst = 1'b0;
        run("to13", 5, 0, 13);
        mode = 1'b1; rst = 1'b1;
        tick();
        check("midrst outs A", a_outs(), 0);
        rst = 1'b0;
        run("after_rst", 5, 0, 20);
        run("after_rst_fast", 2, 0, 8);
        $display("phase mid-period reset done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
